alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Command-level controller in front of the 32-bit ALU. Accepts one command per handshake and issues 1-2 ALU micro-ops.
//  SUB/CMP run as COMP(b) then ADD(a,-b). Keeps the architectural C/Z/N/V flag register.
//  Sits between the decode/execute control and the ALU. It is the only driver of the ALU's op/cin/dir/operand inputs.
// PARAMETERS
//  WIDTH   32  datapath width; must equal the ALU width
//  OP_W    4   command opcode width
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept a command
//  cmd_op     in   OP_W   ADD=0 SUB=1 AND=2 XOR=3 SLL=4 SRL=5 SRA=6 CMP=7; other values are illegal
//  cmd_a      in   WIDTH  operand A (ALU reg1)
//  cmd_b      in   WIDTH  operand B / shift amount (ALU reg2)
//  alu_reg1   out  WIDTH  ALU operand 1
//  alu_reg2   out  WIDTH  ALU operand 2
//  alu_op     out  3      ALU op: ADD=000 COMP=001 AND=010 XOR=011 SHIFT_L=100 SHIFT_A=101
//  alu_cin    out  1      ALU carry-in (always 0 in this block)
//  alu_dir    out  1      logic-shift direction: 0=left, 1=right
//  alu_res    in   WIDTH  ALU result
//  alu_carry  in   1      ALU carry-out; sampled on ADD passes only
//  alu_ovf    in   1      ALU overflow; sampled on ADD passes only
//  rsp_valid  out  1      result available
//  rsp_ready  in   1      consumer accepts the result
//  rsp_data   out  WIDTH  final result
//  rsp_wb     out  1      1 = write back; 0 for CMP and illegal ops
//  rsp_err    out  1      illegal opcode
//  flag_c, flag_z, flag_n, flag_v  out 1 each  architectural flags (registered)
// BEHAVIOUR
//  - FSM states: IDLE, PASS1, PASS2, RESP. cmd_ready = (state==IDLE). Command is accepted on cmd_valid&&cmd_ready.
//  - Command fields are latched on accept. ALU inputs are driven from the latched copy only, never from cmd_* directly.
//  - IDLE -> PASS1 on accept. Illegal op: IDLE -> RESP directly, with rsp_data=cmd_a, rsp_err=1, rsp_wb=0, flags untouched.
//  - PASS1, single-pass ops: ADD->ADD; AND/XOR direct; SLL->SHIFT_L dir0; SRL->SHIFT_L dir1; SRA->SHIFT_A.
//    alu_res is captured into rsp_data, then -> RESP.
//  - PASS1 for SUB/CMP: COMP with reg2=b; capture into tmp; -> PASS2.
//    PASS2: ADD with reg1=a, reg2=tmp, cin=0; capture; -> RESP.
//  - Latency: rsp_valid rises 1 clk after the accept edge for single-pass ops, 2 clks for SUB/CMP.
//  - RESP: rsp_valid=1. rsp_data/rsp_wb/rsp_err are held stable until rsp_valid&&rsp_ready; then -> IDLE.
//  - Flags commit on the final-pass capture edge, not at the response handshake.
//    Z = (result==0) and N = result[WIDTH-1], both computed locally; ALU Z/N outputs are ignored.
//    C/V are updated only by ADD/SUB/CMP (from the ADD pass) and retained for all other ops.
//  - b=0x80000000 on SUB: COMP returns 0x80000000; the ALU ADD flags are reported as-is.
//  - In non-IDLE states, idle ALU inputs are held at op=ADD, operands 0.
//  - Reset (rst==0 at a clk edge), in any state including mid-PASS2: next state IDLE.
//    rsp_valid=0, rsp_data=0, rsp_wb=0, rsp_err=0, all flags=0, tmp=0, alu_* outputs=0; cmd_ready=1 after reset.
//    Any in-flight command is dropped.
// CONFIGURATION
//  ALU_SEQ_BACK2BACK_EN defined:
//    cmd_ready = IDLE || (RESP && rsp_ready).
//    A command accepted in RESP goes straight to PASS1 (or to RESP if illegal), giving 1 command/clk for single-pass ops.
//  ALU_SEQ_BACK2BACK_EN undefined: there is one mandatory IDLE bubble between commands.
// STRUCTURE
//  - alu_seq_pkg: command opcodes, ALU op encodings, FSM state encoding, flag-index constants.
//  - One sub-module, alu_flag_reg: the C/Z/N/V register with separate update enables for the C/V and Z/N groups.
//  - The ALU is instantiated by the parent, not inside this block.
// TESTING
//  - ADD a=0x7FFFFFFF b=1 -> rsp_data=0x80000000, N=1, V=1, C=0, Z=0; rsp_valid 1 clk after accept.
//  - SUB a=5 b=5 -> COMP pass then ADD pass, rsp_data=0, Z=1, C=1, V=0, rsp_wb=1; rsp_valid 2 clks after accept.
//  - CMP a=3 b=7 -> rsp_wb=0, rsp_data=0xFFFFFFFC, N=1, C=0.
//    Then AND 0xF0F0,0x0FF0 -> rsp_data=0x00F0, Z=0, N=0, C/V still hold the CMP values.
//  - Hold rsp_ready=0 for 5 clks with cmd_valid=1 -> rsp_data is stable, cmd_ready=0, second command is not accepted.
//  - Drive rst=0 during PASS2 of SUB -> next clk state=IDLE, rsp_valid=0, all flags 0, cmd_ready=1, no response issued.
//  - Illegal op 4'hF, a=0x1234 -> rsp_err=1, rsp_data=0x1234, flags unchanged.
//    With ALU_SEQ_BACK2BACK_EN: XOR accepted in the same clk as the handshake, rsp_valid on the next clk.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: command opcodes, ALU micro-op codes,
// FSM states, flag indices and small opcode-classification helpers.
package alu_seq_pkg;

  localparam int DATA_W    = 32;
  localparam int CMD_W     = 4;
  localparam int NUM_FLAGS = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  localparam logic [CMD_W-1:0] CMD_ADD = 4'd0;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd1;
  localparam logic [CMD_W-1:0] CMD_AND = 4'd2;
  localparam logic [CMD_W-1:0] CMD_XOR = 4'd3;
  localparam logic [CMD_W-1:0] CMD_SLL = 4'd4;
  localparam logic [CMD_W-1:0] CMD_SRL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SRA = 4'd6;
  localparam logic [CMD_W-1:0] CMD_CMP = 4'd7;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_COMP = 3'b001,
    ALU_AND  = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_SHL  = 3'b100,
    ALU_SHA  = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  function automatic logic is_legal(input logic [CMD_W-1:0] op);
    return (op <= CMD_CMP);
  endfunction

  // SUB and CMP need a negate pass ahead of the add pass
  function automatic logic is_two_pass(input logic [CMD_W-1:0] op);
    return (op == CMD_SUB) || (op == CMD_CMP);
  endfunction

  function automatic logic uses_adder(input logic [CMD_W-1:0] op);
    return (op == CMD_ADD) || (op == CMD_SUB) || (op == CMD_CMP);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command/response handshake bundle between the decode/execute control (master)
// and the ALU sequencer (slave).
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_wb;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_wb, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_wb, rsp_err
  );
endinterface

// File: rtl/alu_flag_reg.sv
// Architectural C/Z/N/V flag register; the C/V and Z/N groups have independent
// update enables so logic/shift ops can refresh Z/N while C/V are retained.
module alu_flag_reg
  import alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cv_en,
  input  logic                 zn_en,
  input  logic                 c_in,
  input  logic                 v_in,
  input  logic                 z_in,
  input  logic                 n_in,
  output logic [NUM_FLAGS-1:0] flags
);

  logic [NUM_FLAGS-1:0] flags_r;

  // Flag storage, each group written only on its own enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_r <= '0;
    end else begin
      if (cv_en) begin
        flags_r[FLAG_C] <= c_in;
        flags_r[FLAG_V] <= v_in;
      end
      if (zn_en) begin
        flags_r[FLAG_Z] <= z_in;
        flags_r[FLAG_N] <= n_in;
      end
    end
  end

  assign flags = flags_r;

endmodule

// File: rtl/alu_sequencer.sv
// Command-level controller in front of the 32-bit ALU: one command per handshake, 1-2 ALU
// micro-ops, architectural flags. Define ALU_SEQ_BACK2BACK_EN to accept a new command in RESP.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
)(
  input  logic             clk,
  input  logic             rst,
  alu_seq_if.slave         bus,
  output logic [WIDTH-1:0] alu_reg1,
  output logic [WIDTH-1:0] alu_reg2,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  output logic             alu_dir,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  seq_state_e           state_r;
  logic [OP_W-1:0]      op_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [WIDTH-1:0]     tmp_r;
  logic                 rsp_valid_r;
  logic [WIDTH-1:0]     rsp_data_r;
  logic                 rsp_wb_r;
  logic                 rsp_err_r;
  logic                 cmd_ready_s;
  logic                 accept_s;
  logic                 cmd_legal_s;
  logic                 final_pass_s;
  logic [NUM_FLAGS-1:0] flags_s;

`ifdef ALU_SEQ_BACK2BACK_EN
  assign cmd_ready_s = (state_r == ST_IDLE) || ((state_r == ST_RESP) && bus.rsp_ready);
`else
  assign cmd_ready_s = (state_r == ST_IDLE);
`endif

  assign accept_s     = bus.cmd_valid && cmd_ready_s;
  assign cmd_legal_s  = is_legal(bus.cmd_op);
  assign final_pass_s = ((state_r == ST_PASS1) && !is_two_pass(op_r)) || (state_r == ST_PASS2);

  // Sequencer FSM together with the latched command and the response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      tmp_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_wb_r    <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_PASS1: begin
          if (is_two_pass(op_r)) begin
            tmp_r   <= alu_res;
            state_r <= ST_PASS2;
          end else begin
            rsp_data_r  <= alu_res;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_PASS2: begin
          rsp_data_r  <= alu_res;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      // Acceptance overrides the RESP->IDLE step when back-to-back issue is enabled
      if (accept_s) begin
        op_r      <= bus.cmd_op;
        a_r       <= bus.cmd_a;
        b_r       <= bus.cmd_b;
        rsp_err_r <= !cmd_legal_s;
        rsp_wb_r  <= cmd_legal_s && (bus.cmd_op != CMD_CMP);
        if (cmd_legal_s) begin
          state_r <= ST_PASS1;
        end else begin
          rsp_data_r  <= bus.cmd_a;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
      end
    end
  end

  // ALU micro-op drive from the latched command; all-zero (ADD of 0,0) outside the passes
  always_comb begin
    alu_reg1 = '0;
    alu_reg2 = '0;
    alu_op   = ALU_ADD;
    alu_cin  = 1'b0;
    alu_dir  = 1'b0;
    case (state_r)
      ST_PASS1: begin
        alu_reg1 = a_r;
        alu_reg2 = b_r;
        case (op_r)
          CMD_ADD: alu_op = ALU_ADD;
          CMD_SUB, CMD_CMP: begin
            alu_op   = ALU_COMP;
            alu_reg1 = '0;
          end
          CMD_AND: alu_op = ALU_AND;
          CMD_XOR: alu_op = ALU_XOR;
          CMD_SLL: alu_op = ALU_SHL;
          CMD_SRL: begin
            alu_op  = ALU_SHL;
            alu_dir = 1'b1;
          end
          CMD_SRA: alu_op = ALU_SHA;
          default: begin
            alu_op   = ALU_ADD;
            alu_reg1 = '0;
            alu_reg2 = '0;
          end
        endcase
      end
      ST_PASS2: begin
        alu_op   = ALU_ADD;
        alu_reg1 = a_r;
        alu_reg2 = tmp_r;
      end
      default: begin
        alu_op = ALU_ADD;
      end
    endcase
  end

  // Z/N come from the captured result itself, never from the ALU's own flag outputs
  alu_flag_reg u_flags (
    .clk   (clk),
    .rst   (rst),
    .cv_en (final_pass_s && uses_adder(op_r)),
    .zn_en (final_pass_s),
    .c_in  (alu_carry),
    .v_in  (alu_ovf),
    .z_in  (alu_res == '0),
    .n_in  (alu_res[WIDTH-1]),
    .flags (flags_s)
  );

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_wb    = rsp_wb_r;
  assign bus.rsp_err   = rsp_err_r;

  assign flag_c = flags_s[FLAG_C];
  assign flag_z = flags_s[FLAG_Z];
  assign flag_n = flags_s[FLAG_N];
  assign flag_v = flags_s[FLAG_V];

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU and a
// command-level reference model (result, flags, latency, write-back, error).
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] alu_reg1, alu_reg2, alu_res;
  logic [2:0]  alu_op;
  logic        alu_cin, alu_dir, alu_carry, alu_ovf;
  logic        flag_c, flag_z, flag_n, flag_v;
  logic [32:0] alu_sum;

  int total = 0;
  int bad   = 0;
  logic m_c = 1'b0, m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;

  alu_seq_if #(.WIDTH(32), .OP_W(4)) ifc ();

  alu_sequencer #(.WIDTH(32), .OP_W(4)) dut (
    .clk (clk), .rst (rst), .bus (ifc),
    .alu_reg1 (alu_reg1), .alu_reg2 (alu_reg2), .alu_op (alu_op),
    .alu_cin (alu_cin), .alu_dir (alu_dir), .alu_res (alu_res),
    .alu_carry (alu_carry), .alu_ovf (alu_ovf),
    .flag_c (flag_c), .flag_z (flag_z), .flag_n (flag_n), .flag_v (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU seen by the sequencer
  always_comb begin
    alu_sum   = {1'b0, alu_reg1} + {1'b0, alu_reg2} + {32'd0, alu_cin};
    alu_res   = 32'd0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_res   = alu_sum[31:0];
        alu_carry = alu_sum[32];
        alu_ovf   = (alu_reg1[31] == alu_reg2[31]) && (alu_sum[31] != alu_reg1[31]);
      end
      3'b001: alu_res = ~alu_reg2 + 32'd1;
      3'b010: alu_res = alu_reg1 & alu_reg2;
      3'b011: alu_res = alu_reg1 ^ alu_reg2;
      3'b100: alu_res = alu_dir ? (alu_reg1 >> alu_reg2[4:0]) : (alu_reg1 << alu_reg2[4:0]);
      3'b101: alu_res = $signed(alu_reg1) >>> alu_reg2[4:0];
      default: alu_res = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Command-level reference: a - b is a + (-b), carry/overflow of that addition
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic wb, output logic err,
                           output logic c, output logic v, output int lat,
                           output logic [2:0] aop, output logic dir);
    logic [32:0] s;
    logic [31:0] nb;
    nb = 32'd0 - b;
    res = a; wb = 1'b1; err = 1'b0; c = 1'b0; v = 1'b0; lat = 1; aop = 3'd0; dir = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        res = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (res[31] != a[31]);
      end
      4'd1, 4'd7: begin
        s = {1'b0, a} + {1'b0, nb};
        res = s[31:0]; c = s[32];
        v = (a[31] == nb[31]) && (res[31] != a[31]);
        lat = 2; aop = 3'd1; wb = (op == 4'd1);
      end
      4'd2: begin res = a & b; aop = 3'd2; end
      4'd3: begin res = a ^ b; aop = 3'd3; end
      4'd4: begin res = a << b[4:0]; aop = 3'd4; end
      4'd5: begin res = a >> b[4:0]; aop = 3'd4; dir = 1'b1; end
      4'd6: begin res = $signed(a) >>> b[4:0]; aop = 3'd5; end
      default: begin res = a; wb = 1'b0; err = 1'b1; lat = 0; end
    endcase
  endtask

  function automatic logic [63:0] mflags();
    return {60'd0, m_v, m_n, m_z, m_c};
  endfunction

  function automatic logic [63:0] dflags();
    return {60'd0, flag_v, flag_n, flag_z, flag_c};
  endfunction

  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    logic [31:0] e_res;
    logic        e_wb, e_err, e_c, e_v, e_dir;
    logic [2:0]  e_aop;
    int          e_lat, n, lat;
    ref_model(op, a, b, e_res, e_wb, e_err, e_c, e_v, e_lat, e_aop, e_dir);
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = op; ifc.cmd_a = a; ifc.cmd_b = b; ifc.rsp_ready = 1'b0;
    n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("accept_wait", 64'(ifc.cmd_ready), 64'd1);
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0; ifc.cmd_op = 4'($urandom); ifc.cmd_a = $urandom; ifc.cmd_b = $urandom;
    if (!e_err) begin
      check("pass1_op", 64'(alu_op), 64'(e_aop));
      check("pass1_dir", 64'(alu_dir), 64'(e_dir));
      check("pass1_reg2", 64'(alu_reg2), 64'(b));
      check("busy_ready", 64'(ifc.cmd_ready), 64'd0);
    end
    lat = 0;
    while (ifc.rsp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1 && e_lat == 2) begin
        check("pass2_op", 64'(alu_op), 64'd0);
        check("pass2_ops", {alu_reg1, alu_reg2}, {a, 32'd0 - b});
      end
    end
    check("latency", 64'(lat), 64'(e_lat));
    if (!e_err) begin
      m_z = (e_res == 32'd0);
      m_n = e_res[31];
      if (op == 4'd0 || op == 4'd1 || op == 4'd7) begin m_c = e_c; m_v = e_v; end
    end
    check("rsp_data", 64'(ifc.rsp_data), 64'(e_res));
    check("rsp_wb_err", {62'd0, ifc.rsp_wb, ifc.rsp_err}, {62'd0, e_wb, e_err});
    check("flags", dflags(), mflags());
    check("resp_alu_idle", {29'd0, alu_op, alu_reg1}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      ifc.cmd_valid = 1'b1; ifc.cmd_op = 4'd3;
      @(posedge clk); #1;
      check("hold_data", 64'(ifc.rsp_data), 64'(e_res));
      check("hold_vr", {62'd0, ifc.rsp_valid, ifc.cmd_ready}, 64'd2);
    end
    ifc.cmd_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    #1;
`ifdef ALU_SEQ_BACK2BACK_EN
    check("resp_ready_b2b", 64'(ifc.cmd_ready), 64'd1);
`else
    check("resp_bubble", 64'(ifc.cmd_ready), 64'd0);
`endif
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
    check("rsp_drop", 64'(ifc.rsp_valid), 64'd0);
  endtask

  task automatic reset_in_pass2();
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = 4'd1; ifc.cmd_a = 32'd9; ifc.cmd_b = 32'd4; ifc.rsp_ready = 1'b0;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_pass2", {alu_reg1, alu_reg2}, {32'd9, 32'hFFFF_FFFC});
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
    check("rst_vr", {62'd0, ifc.rsp_valid, ifc.cmd_ready}, 64'd1);
    check("rst_flags", dflags(), 64'd0);
    check("rst_alu", {alu_reg1, alu_reg2}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_rsp", 64'(ifc.rsp_valid), 64'd0);
  endtask

  task automatic issue_after_illegal();
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = 4'hF; ifc.cmd_a = 32'h1234; ifc.cmd_b = 32'h0; ifc.rsp_ready = 1'b0;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    check("ill_rsp", {30'd0, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_data}, {30'd0, 2'b11, 32'h1234});
    @(negedge clk);
    ifc.rsp_ready = 1'b1; ifc.cmd_valid = 1'b1; ifc.cmd_op = 4'd3;
    ifc.cmd_a = 32'hA5A5_0F0F; ifc.cmd_b = 32'hFFFF_0000;
    #1;
`ifdef ALU_SEQ_BACK2BACK_EN
    check("b2b_ready", 64'(ifc.cmd_ready), 64'd1);
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0; ifc.cmd_valid = 1'b0;
    check("b2b_pass1", {61'd0, ifc.rsp_valid, alu_op}, 64'(3'd3));
    @(posedge clk); #1;
    check("b2b_rsp", {29'd0, ifc.rsp_valid, ifc.rsp_wb, ifc.rsp_err, ifc.rsp_data},
          {29'd0, 3'b110, 32'h5A5A_0F0F});
    m_z = 1'b0; m_n = 1'b0;
    ifc.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
`else
    check("bubble_ready", 64'(ifc.cmd_ready), 64'd0);
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0; ifc.cmd_valid = 1'b0;
    check("bubble_idle", {62'd0, ifc.rsp_valid, ifc.cmd_ready}, 64'd1);
    @(posedge clk); #1;
    check("bubble_no_rsp", 64'(ifc.rsp_valid), 64'd0);
`endif
    check("after_ill_flags", dflags(), mflags());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] corners [6];
    logic [31:0] a, b;
    logic [3:0]  op;
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd31};
    rst = 1'b0;
    ifc.cmd_valid = 1'b0; ifc.cmd_op = 4'd0; ifc.cmd_a = 32'd0; ifc.cmd_b = 32'd0; ifc.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vr", {62'd0, ifc.rsp_valid, ifc.cmd_ready}, 64'd1);
    check("reset_rsp", {30'd0, ifc.rsp_wb, ifc.rsp_err, ifc.rsp_data}, 64'd0);
    check("reset_flags", dflags(), 64'd0);
    check("reset_alu", {27'd0, alu_op, alu_cin, alu_dir, alu_reg1}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_cmd(4'd0, 32'h7FFF_FFFF, 32'd1, 0);
    run_cmd(4'd1, 32'd5, 32'd5, 0);
    run_cmd(4'd7, 32'd3, 32'd7, 0);
    run_cmd(4'd2, 32'h0000_F0F0, 32'h0000_0FF0, 0);
    run_cmd(4'd6, 32'h8000_0010, 32'd4, 5);
    run_cmd(4'd1, 32'd0, 32'h8000_0000, 0);
    run_cmd(4'hF, 32'h1234, 32'd0, 1);
    reset_in_pass2();
    run_cmd(4'd5, 32'h8000_0000, 32'd31, 0);
    run_cmd(4'd4, 32'h0000_0001, 32'd31, 0);
    issue_after_illegal();

    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      run_cmd(op, a, b, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
